rv32i_dmem: RTL and testbench



---
 rtl/rv32i_pkg.sv | 63 ++++++
 rtl/rv32i_dmem_if.sv | 32 +++
 rtl/rv32i_dmem_ram.sv | 34 +++
 rtl/rv32i_dmem.sv | 146 ++++++++++++++
 tb/tb_rv32i_dmem.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// ============================================================================
//  rv32i_pkg
//  Shared types, access-size codes and lane-steering helpers for rv32i_dmem.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'b11) ||
           (size == MEM_H && lane[0]) ||
           (size == MEM_W && lane != 2'b00);
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      MEM_B:   be = 4'b0001 << lane;
      MEM_H:   be = lane[1] ? 4'b1100 : 4'b0011;
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Stores replicate the right-aligned datum into every lane it could land in.
  function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [1:0] size);
    logic [31:0] d;
    case (size)
      MEM_B:   d = {4{wdata[7:0]}};
      MEM_H:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (size)
      MEM_B:   r = {{24{sh[7] & ~uns}}, sh[7:0]};
      MEM_H:   r = {{16{sh[15] & ~uns}}, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_dmem_if.sv
// ============================================================================
//  rv32i_dmem_if
//  Request/response bus between the memory stage (master) and data memory.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface rv32i_dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/rv32i_dmem_ram.sv
// ============================================================================
//  rv32i_dmem_ram
//  Synchronous single-port word RAM, 4-bit byte write enable.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rv32i_dmem_ram #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  // An access with no byte enables is a read; rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (be == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv32i_dmem.sv
// ============================================================================
//  rv32i_dmem
//  RV32I data-memory responder: byte/half/word loads and stores with error flag.
//  Optional wait states: define RV32I_DMEM_WAIT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rv32i_dmem
  import rv32i_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic         clk,
  input  logic         reset,
  rv32i_dmem_if.slave  bus
);

  dmem_state_e           state;
  logic                  w_accept;
  logic                  w_req_err;
  logic                  r_valid;
  logic                  r_err;
  logic                  r_we;
  logic                  r_unsigned;
  logic [1:0]            r_size;
  logic [1:0]            r_lane;
  logic                  w_ram_en;
  logic [3:0]            w_ram_be;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [31:0]           w_ram_wdata;
  logic [31:0]           w_ram_rdata;

`ifdef RV32I_DMEM_WAIT_EN
  localparam bit         DIRECT    = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
`else
  localparam bit         DIRECT    = 1'b1;
`endif

  assign bus.req_ready = (state == IDLE) || (state == RESP && bus.rsp_ready);
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_req_err     = bad_access(bus.req_size, bus.req_addr[1:0]) ||
                         ((bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  // RAM port is driven from the live request on a direct accept, or from the
  // captured request when a wait-state countdown expires.
  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_be    = byte_en(bus.req_size, bus.req_addr[1:0]) & {4{bus.req_we}};
    w_ram_addr  = bus.req_addr[ADDR_WIDTH+1:2];
    w_ram_wdata = store_data(bus.req_wdata, bus.req_size);
    if (DIRECT) w_ram_en = w_accept && !w_req_err;
`ifdef RV32I_DMEM_WAIT_EN
    if (state == BUSY) begin
      w_ram_en    = (r_cnt == 4'd0);
      w_ram_be    = byte_en(r_size, r_lane) & {4{r_we}};
      w_ram_addr  = r_waddr;
      w_ram_wdata = store_data(r_wdata, r_size);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= MEM_B;
      r_lane     <= 2'b00;
`ifdef RV32I_DMEM_WAIT_EN
      r_cnt      <= 4'd0;
      r_waddr    <= '0;
      r_wdata    <= 32'd0;
`endif
    end else begin
      case (state)
`ifdef RV32I_DMEM_WAIT_EN
        BUSY: begin
          if (r_cnt == 4'd0) begin
            state   <= RESP;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`endif
        IDLE, RESP: begin
          if (w_accept) begin
            r_we       <= bus.req_we;
            r_unsigned <= bus.req_unsigned;
            r_size     <= bus.req_size;
            r_lane     <= bus.req_addr[1:0];
            r_err      <= w_req_err;
`ifdef RV32I_DMEM_WAIT_EN
            r_waddr    <= bus.req_addr[ADDR_WIDTH+1:2];
            r_wdata    <= bus.req_wdata;
`endif
            if (w_req_err || DIRECT) begin
              state   <= RESP;
              r_valid <= 1'b1;
            end
`ifdef RV32I_DMEM_WAIT_EN
            else begin
              state   <= BUSY;
              r_valid <= 1'b0;
              r_cnt   <= WAIT_INIT;
            end
`endif
          end else if (state == RESP && bus.rsp_ready) begin
            state   <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = r_valid;
  assign bus.rsp_err   = r_valid && r_err;
  assign bus.rsp_rdata = (r_valid && !r_err && !r_we) ?
                         load_ext(w_ram_rdata, r_size, r_lane, r_unsigned) : 32'd0;

  rv32i_dmem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (w_ram_en),
    .be    (w_ram_be),
    .addr  (w_ram_addr),
    .wdata (w_ram_wdata),
    .rdata (w_ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_rv32i_dmem.sv
// ============================================================================
//  tb_rv32i_dmem
//  Randomized self-checking bench for rv32i_dmem against a byte-addressed model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rv32i_dmem;

  localparam int AW    = 10;
  localparam int WAITS = 2;
`ifdef RV32I_DMEM_WAIT_EN
  localparam int EXTRA = WAITS;
`else
  localparam int EXTRA = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  rv32i_dmem_if bus ();

  rv32i_dmem #(
    .ADDR_WIDTH  (AW),
    .WAIT_CYCLES (WAITS),
    .INIT_FILE   ("")
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mbytes [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00) ||
           (a >= 32'(4 << AW));
  endfunction

  // Memory as a flat byte array; little-endian assembly and extension from scratch.
  function automatic logic [31:0] model_access(input bit we, input logic [31:0] a,
                                               input logic [31:0] wd, input logic [1:0] s,
                                               input bit u);
    int          n;
    logic [31:0] v;
    n = 1 << s;
    v = 32'd0;
    if (model_err(a, s)) return 32'd0;
    for (int k = 0; k < n; k++) begin
      if (we) mbytes[int'(a) + k] = wd[8*k +: 8];
      else    v[8*k +: 8] = mbytes.exists(int'(a) + k) ? mbytes[int'(a) + k] : 8'h00;
    end
    if (we) return 32'd0;
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic txn(input string tag, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [1:0] s, input bit u,
                     input int hold, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bit          exp_e;
    int          exp_lat;
    int          lat;
    int          waitc;
    exp_e   = model_err(a, s);
    exp_rd  = model_access(we, a, wd, s, u);
    exp_lat = exp_e ? 1 : 1 + EXTRA;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_size     = s;
    bus.req_unsigned = u;
    bus.rsp_ready    = 1'b0;
    waitc = 0;
    while (!bus.req_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_accept_bound"}, 32'(waitc < 100), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_e));
    check({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
    rd = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rd);
      check({tag, "_hold_err"}, 32'(bus.rsp_err), 32'(exp_e));
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_release"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic [1:0]  s;
    bit          we;
    bit          u;

    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) txn("init", 1'b1, 32'(i * 4), $urandom, 2'b10, 1'b0, 0, rd);

    txn("sw", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, rd);
    txn("lw", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 0, rd);
    check("lw_const", rd, 32'hDEAD_BEEF);
    txn("sb", 1'b1, 32'h13, 32'h0000_0080, 2'b00, 1'b0, 0, rd);
    txn("lb", 1'b0, 32'h13, 32'd0, 2'b00, 1'b0, 0, rd);
    check("lb_const", rd, 32'hFFFF_FF80);
    txn("lbu", 1'b0, 32'h13, 32'd0, 2'b00, 1'b1, 0, rd);
    check("lbu_const", rd, 32'h0000_0080);
    txn("lw_merge", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 0, rd);
    check("lw_merge_const", rd, 32'h80AD_BEEF);

    txn("lh_misaligned", 1'b0, 32'h11, 32'd0, 2'b01, 1'b0, 0, rd);
    txn("size_illegal", 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, 0, rd);
    txn("sw0", 1'b1, 32'h0, 32'hCAFE_F00D, 2'b10, 1'b0, 0, rd);
    txn("sw_range", 1'b1, 32'h4000, 32'h1111_1111, 2'b10, 1'b0, 0, rd);
    txn("lw0", 1'b0, 32'h0, 32'd0, 2'b10, 1'b0, 0, rd);
    check("lw0_const", rd, 32'hCAFE_F00D);
    txn("lw_hold", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 4, rd);

    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << s) - 32'd1);
      if ($urandom_range(0, 15) == 0) s = 2'b11;
      if ($urandom_range(0, 15) == 0) a = a | 32'h0000_1000;
      txn("rnd", we, a, $urandom, s, u, $urandom_range(0, 2), rd);
    end

`ifndef RV32I_DMEM_WAIT_EN
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a   = 32'h60 + 32'((i / 2) * 4);
      we  = (i % 2 == 0);
      wd  = $urandom;
      exp = model_access(we, a, wd, 2'b10, 1'b0);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      check("b2b_ready", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1;
      check("b2b_valid", 32'(bus.rsp_valid), 32'd1);
      check("b2b_rdata", bus.rsp_rdata, exp);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_idle", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;
`endif

    txn("pre_reset_sw", 1'b1, 32'h20, 32'hA5A5_5A5A, 2'b10, 1'b0, 0, rd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_addr     = 32'h20;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
`ifdef RV32I_DMEM_WAIT_EN
    bus.req_we    = 1'b1;
    bus.req_wdata = 32'h1234_5678;
`else
    bus.req_we    = 1'b0;
    bus.req_wdata = 32'd0;
`endif
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("mid_reset_hold");
    @(negedge clk);
    reset = 1'b0;
    txn("post_reset_lw", 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 0, rd);
    check("post_reset_const", rd, 32'hA5A5_5A5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
